// File: rtl/highscore_display.sv
// highscore_display
//   Keeps the highest 4-digit score seen since reset and drives six
//   active-low 7-segment displays (segment order {g,f,e,d,c,b,a}).
//
//   Ports:
//     clk        system clock, all state on the rising edge
//     reset      synchronous active-high, clears the stored high score
//     on         1: show stored high score with "HI" on out5/out4
//                0: show live score, out5/out4 blank
//     hex0..3    live score digits, hex0 least significant
//     out0..3    segments for the selected digits
//     out4       "I" glyph or blank
//     out5       "H" glyph or blank

// seg7: combinational hex-digit to active-low segment decoder.
module seg7 (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b1111111;
        case (digit)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

// compare: registered running-maximum of the 16-bit live score.
//   Ports: clk, reset (sync, active-high), score (live), hi (stored max).
module compare (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] score,
    output logic [15:0] hi
);
    logic [15:0] hi_p1;

    // Stage p1: plain unsigned compare; nibbles A-F simply weigh more,
    // and an equal score leaves the register untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_p1 <= 16'h0000;
        end else if (score > hi_p1) begin
            hi_p1 <= score;
        end
    end

    assign hi = hi_p1;
endmodule

module highscore_display (
    input  logic       clk,
    input  logic       reset,
    input  logic       on,
    input  logic [3:0] hex0,
    input  logic [3:0] hex1,
    input  logic [3:0] hex2,
    input  logic [3:0] hex3,
    output logic [6:0] out0,
    output logic [6:0] out1,
    output logic [6:0] out2,
    output logic [6:0] out3,
    output logic [6:0] out4,
    output logic [6:0] out5
);
    localparam logic [6:0] GLYPH_I     = 7'b1111001;
    localparam logic [6:0] GLYPH_H     = 7'b0001001;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    logic [15:0] score;
    logic [15:0] hi;
    logic [3:0]  pick0, pick1, pick2, pick3;

    assign score = {hex3, hex2, hex1, hex0};

    compare u_compare (
        .clk   (clk),
        .reset (reset),
        .score (score),
        .hi    (hi)
    );

    // Display mux is purely combinational so the live score shows with no
    // latency; the stored score only lags by the compare register.
    always_comb begin
        pick0 = hex0;
        pick1 = hex1;
        pick2 = hex2;
        pick3 = hex3;
        out4  = GLYPH_BLANK;
        out5  = GLYPH_BLANK;
        if (on) begin
            pick0 = hi[3:0];
            pick1 = hi[7:4];
            pick2 = hi[11:8];
            pick3 = hi[15:12];
            out4  = GLYPH_I;
            out5  = GLYPH_H;
        end
    end

    seg7 u_seg0 (.digit(pick0), .seg(out0));
    seg7 u_seg1 (.digit(pick1), .seg(out1));
    seg7 u_seg2 (.digit(pick2), .seg(out2));
    seg7 u_seg3 (.digit(pick3), .seg(out3));
endmodule

// File: tb/tb_highscore_display.sv
// tb_highscore_display
//   Directed bench for highscore_display: reset state, live display,
//   high-score capture, mid-run reset, display-select independence and an
//   ascending sweep of every score with a running-maximum model.
module tb_highscore_display;
    logic       clk;
    logic       reset;
    logic       on;
    logic [3:0] hex0, hex1, hex2, hex3;
    logic [6:0] out0, out1, out2, out3, out4, out5;

    int n_cmp;
    int n_bad;

    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D9 = 7'b0010000;
    localparam logic [6:0] GI = 7'b1111001;
    localparam logic [6:0] GH = 7'b0001001;
    localparam logic [6:0] BL = 7'b1111111;

    logic [6:0] segtab [16];

    highscore_display dut (
        .clk   (clk),
        .reset (reset),
        .on    (on),
        .hex0  (hex0),
        .hex1  (hex1),
        .hex2  (hex2),
        .hex3  (hex3),
        .out0  (out0),
        .out1  (out1),
        .out2  (out2),
        .out3  (out3),
        .out4  (out4),
        .out5  (out5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_score(input logic [15:0] s);
        {hex3, hex2, hex1, hex0} = s;
    endtask

    function automatic logic [41:0] expect_disp(input logic o, input logic [15:0] s,
                                                input logic [15:0] h);
        logic [15:0] v;
        v = o ? h : s;
        return {(o ? GH : BL), (o ? GI : BL),
                segtab[v[15:12]], segtab[v[11:8]], segtab[v[7:4]], segtab[v[3:0]]};
    endfunction

    initial begin
        logic [15:0] hi_m;
        logic [15:0] s;

        segtab[0]  = 7'b1000000; segtab[1]  = 7'b1111001;
        segtab[2]  = 7'b0100100; segtab[3]  = 7'b0110000;
        segtab[4]  = 7'b0011001; segtab[5]  = 7'b0010010;
        segtab[6]  = 7'b0000010; segtab[7]  = 7'b1111000;
        segtab[8]  = 7'b0000000; segtab[9]  = 7'b0010000;
        segtab[10] = 7'b0001000; segtab[11] = 7'b0000011;
        segtab[12] = 7'b1000110; segtab[13] = 7'b0100001;
        segtab[14] = 7'b0000110; segtab[15] = 7'b0001110;

        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        on    = 1'b1;
        set_score(16'h0000);

        // Reset state
        tick();
        check("rst_digits", {out3, out2, out1, out0}, {D0, D0, D0, D0});
        check("rst_out4", out4, GI);
        check("rst_out5", out5, GH);

        // Live display, zero latency
        reset = 1'b0;
        on    = 1'b0;
        set_score(16'h1234);
        #1;
        check("live_digits", {out3, out2, out1, out0}, {D1, D2, D3, D4});
        check("live_blank", {out5, out4}, {BL, BL});

        // Capture
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_score(16'h0250);
        tick();
        set_score(16'h0100);
        on = 1'b1;
        #1;
        check("cap_0250", {out3, out2, out1, out0}, {D0, D2, D5, D0});
        tick();
        check("cap_hold_lower", {out3, out2, out1, out0}, {D0, D2, D5, D0});
        set_score(16'h0251);
        #1;
        check("cap_latency", {out3, out2, out1, out0}, {D0, D2, D5, D0});
        tick();
        check("cap_0251", {out3, out2, out1, out0}, {D0, D2, D5, D1});
        tick();
        check("cap_equal", {out3, out2, out1, out0}, {D0, D2, D5, D1});

        // Reset mid-operation
        set_score(16'h0999);
        tick();
        check("mid_0999", {out3, out2, out1, out0}, {D0, D9, D9, D9});
        reset = 1'b1;
        set_score(16'h1000);
        tick();
        check("mid_reset_prio", {out3, out2, out1, out0}, {D0, D0, D0, D0});
        reset = 1'b0;
        tick();
        check("mid_1000", {out3, out2, out1, out0}, {D1, D0, D0, D0});

        // Update continues while on=0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        on = 1'b0;
        set_score(16'h0010);
        tick();
        set_score(16'h0042);
        tick();
        set_score(16'h0000);
        #1;
        check("indep_live", {out3, out2, out1, out0}, {D0, D0, D0, D0});
        on = 1'b1;
        #1;
        check("indep_0042", {out3, out2, out1, out0}, {D0, D0, D4, segtab[2]});

        // Ascending sweep of every score, alternating display select
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hi_m = 16'h0000;
        for (int i = 0; i < 65536; i++) begin
            s = i[15:0];
            on = s[0];
            set_score(s);
            #1;
            check($sformatf("sweep_%04h", s), {out5, out4, out3, out2, out1, out0},
                  expect_disp(on, s, hi_m));
            tick();
            if (s > hi_m) hi_m = s;
        end
        on = 1'b1;
        set_score(16'h0000);
        #1;
        check("sweep_final", {out5, out4, out3, out2, out1, out0},
              {GH, GI, segtab[15], segtab[15], segtab[15], segtab[15]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
